// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle execute unit: 1-cycle integer ops, FP ops via external FPU handshake
//
// Ports:
//   clk, rstn                   clock; synchronous active-high reset
//   in_valid/in_ready           operation handshake (alu_control, src_a, src_b)
//   out_valid/out_ready         result register handshake (result, zero)
//   busy                        high while waiting on the FPU
//   fpu_req/fpu_op              one-cycle launch pulse with one-hot opcode
//   fpu_x1/fpu_x2               FPU operands, held until completion
//   fpu_y/fpu_valid             FPU result and completion strobe
module alu_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy,
    output logic            fpu_req,
    output logic [7:0]      fpu_op,
    output logic [XLEN-1:0] fpu_x1,
    output logic [XLEN-1:0] fpu_x2,
    input  logic [XLEN-1:0] fpu_y,
    input  logic            fpu_valid
);

    typedef enum logic {IDLE = 1'b0, FPU_WAIT = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [XLEN-1:0]   int_res;
    logic [7:0]        fp_onehot;
    logic              accept;
    logic              launch;
    logic              fpu_done;
    logic [SHW-1:0]    shamt;

    assign shamt = src_b[SHW-1:0];

    // The slot is free when empty or when its current result drains this cycle.
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign launch   = accept && alu_control[4] && (fp_onehot != 8'h00);
    assign fpu_done = (state == FPU_WAIT) && fpu_valid;

    always_comb begin
        int_res = '0;
        case (alu_control)
            5'b00000: int_res = src_a & src_b;
            5'b00001: int_res = src_a | src_b;
            5'b00010: int_res = src_a + src_b;
            5'b00011: int_res = src_a ^ src_b;
            5'b00100: int_res = src_a << shamt;
            5'b00101: int_res = src_a >> shamt;
            5'b00110: int_res = src_a - src_b;
            5'b00111: int_res = $signed(src_a) >>> shamt;
            5'b01000: int_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            5'b01001: int_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            default:  int_res = '0;
        endcase
    end

    always_comb begin
        fp_onehot = 8'h00;
        case (alu_control)
            5'b10000: fp_onehot = 8'h01;
            5'b10001: fp_onehot = 8'h02;
            5'b10010: fp_onehot = 8'h04;
            5'b10011: fp_onehot = 8'h08;
            5'b11011: fp_onehot = 8'h10;
            5'b10110: fp_onehot = 8'h20;
            5'b10111: fp_onehot = 8'h40;
            5'b10101: fp_onehot = 8'h80;
            default:  fp_onehot = 8'h00;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (launch)    state_nxt = FPU_WAIT;
            FPU_WAIT: if (fpu_valid) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state == FPU_WAIT);
    end

    // FPU launch registers; operands stay put for the whole wait.
    always_ff @(posedge clk) begin
        if (rstn) begin
            fpu_req <= 1'b0;
            fpu_op  <= 8'h00;
            fpu_x1  <= '0;
            fpu_x2  <= '0;
        end else begin
            fpu_req <= launch;
            fpu_op  <= launch ? fp_onehot : 8'h00;
            if (launch) begin
                fpu_x1 <= src_a;
                fpu_x2 <= src_b;
            end
        end
    end

    // Result register. Integer ops and unmapped FP codes complete in one cycle;
    // int_res is already zero for every code with bit 4 set.
    always_ff @(posedge clk) begin
        if (rstn) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else if (accept && !launch) begin
            out_valid <= 1'b1;
            result    <= int_res;
            zero      <= (int_res == '0);
        end else if (fpu_done) begin
            out_valid <= 1'b1;
            result    <= fpu_y;
            zero      <= (fpu_y == '0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
